stream_pattern_monitor: RTL and testbench



---
 rtl/stream_pattern_monitor.sv | 164 ++++++++++++++++
 tb/tb_stream_pattern_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stream_pattern_monitor.sv
// stream_pattern_monitor: observes a single-bit serial stream and reports
// overlapping pattern matches, counts matches and rising edges, and measures
// the length of the most recently completed run of 1s.
// Optional build macro MON_SAT_EN: match/edge counters saturate instead of
// wrapping, and a sticky ovf output flags any increment lost to saturation.
// All outputs are registered; clr behaves like reset but is gated by rstn.
module stream_pattern_monitor #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  parameter int               LEN_W   = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  logic             clr,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [LEN_W-1:0] last_hi_len,
  output logic             len_vld
`ifdef MON_SAT_EN
  ,
  output logic             ovf
`endif
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HIGH = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] RUN_MAX = {LEN_W{1'b1}};

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              prev_q, prev_d;
  logic [0:0]        state_q, state_d;
  logic [LEN_W-1:0]  run_q, run_d;
  logic              det_q, det_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              lenVld_q, lenVld_d;
`ifdef MON_SAT_EN
  logic              ovf_q, ovf_d;
`endif

  logic              hit;
  logic              rise;
  logic              runIncReq;

  // Next-state logic: history shift, match/edge detection, counters, run FSM
  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], din};
    hit      = (hist_d == PATTERN) && (fill_q >= FILL_W'(PAT_W - 1));
    rise     = din & ~prev_q & (fill_q != '0);
    runIncReq = (state_q == HIGH) && din;

    fill_d   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    prev_d   = din;
    det_d    = hit;
    state_d  = state_q;
    run_d    = run_q;
    len_d    = len_q;
    lenVld_d = 1'b0;

`ifdef MON_SAT_EN
    ovf_d   = ovf_q;
    match_d = match_q;
    edge_d  = edge_q;
    if (hit) begin
      if (match_q == CNT_MAX) ovf_d = 1'b1;
      else                    match_d = match_q + CNT_W'(1);
    end
    if (rise) begin
      if (edge_q == CNT_MAX) ovf_d = 1'b1;
      else                   edge_d = edge_q + CNT_W'(1);
    end
    if (runIncReq && (run_q == RUN_MAX)) ovf_d = 1'b1;
`else
    match_d = hit  ? match_q + CNT_W'(1) : match_q;
    edge_d  = rise ? edge_q  + CNT_W'(1) : edge_q;
`endif

    case (state_q)
      IDLE: begin
        if (din) begin
          state_d = HIGH;
          run_d   = LEN_W'(1);
        end
      end
      default: begin
        if (din) begin
          if (run_q != RUN_MAX) run_d = run_q + LEN_W'(1);
        end else begin
          len_d    = run_q;
          lenVld_d = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase

    if (clr) begin
      hist_d   = '0;
      fill_d   = '0;
      prev_d   = 1'b0;
      state_d  = IDLE;
      run_d    = '0;
      det_d    = 1'b0;
      match_d  = '0;
      edge_d   = '0;
      len_d    = '0;
      lenVld_d = 1'b0;
`ifdef MON_SAT_EN
      ovf_d    = 1'b0;
`endif
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q   <= '0;
      fill_q   <= '0;
      prev_q   <= 1'b0;
      state_q  <= IDLE;
      run_q    <= '0;
      det_q    <= 1'b0;
      match_q  <= '0;
      edge_q   <= '0;
      len_q    <= '0;
      lenVld_q <= 1'b0;
`ifdef MON_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      run_q    <= run_d;
      det_q    <= det_d;
      match_q  <= match_d;
      edge_q   <= edge_d;
      len_q    <= len_d;
      lenVld_q <= lenVld_d;
`ifdef MON_SAT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign det         = det_q;
  assign match_cnt   = match_q;
  assign edge_cnt    = edge_q;
  assign last_hi_len = len_q;
  assign len_vld     = lenVld_q;
`ifdef MON_SAT_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_stream_pattern_monitor.sv
// tb_stream_pattern_monitor: directed-vector bench for stream_pattern_monitor
// with default parameters (PAT_W=4, PATTERN=1011, CNT_W=8, LEN_W=6).
// Honours MON_SAT_EN so the same bench covers both the wrapping and the
// saturating builds.
module tb_stream_pattern_monitor;

  logic       clk;
  logic       rstn;
  logic       din;
  logic       clr;
  logic       det;
  logic [7:0] match_cnt;
  logic [7:0] edge_cnt;
  logic [5:0] last_hi_len;
  logic       len_vld;
`ifdef MON_SAT_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  stream_pattern_monitor dut (
    .clk         (clk),
    .rstn        (rstn),
    .din         (din),
    .clr         (clr),
    .det         (det),
    .match_cnt   (match_cnt),
    .edge_cnt    (edge_cnt),
    .last_hi_len (last_hi_len),
    .len_vld     (len_vld)
`ifdef MON_SAT_EN
    ,
    .ovf         (ovf)
`endif
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one din sample, let the DUT take it, then settle just past the edge
  task automatic applyStimulus(input logic d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // All observable outputs must be zero after reset or clr
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".det"}, det, 0);
    checkOutput({tag, ".match_cnt"}, match_cnt, 0);
    checkOutput({tag, ".edge_cnt"}, edge_cnt, 0);
    checkOutput({tag, ".last_hi_len"}, last_hi_len, 0);
    checkOutput({tag, ".len_vld"}, len_vld, 0);
`ifdef MON_SAT_EN
    checkOutput({tag, ".ovf"}, ovf, 0);
`endif
  endtask

  // Directed test sequence
  initial begin
    logic [6:0] ovlSeq;
    logic [6:0] ovlDet;
    logic [6:0] ovlVld;
    logic [5:0] clrSeq;
    logic [5:0] clrDet;

    rstn = 1'b0;
    clr  = 1'b0;
    din  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("por");
    rstn = 1'b1;

    // Reset mid-stream: a run of 1s is discarded, first sample is no edge
    repeat (3) applyStimulus(1'b1);
    checkOutput("pre_rst.edge_cnt", edge_cnt, 0);
    rstn = 1'b0;
    applyStimulus(1'b1);
    checkAllZero("midrst");
    rstn = 1'b1;
    applyStimulus(1'b1);
    checkOutput("post_rst.edge_cnt", edge_cnt, 0);
    checkOutput("post_rst.len_vld", len_vld, 0);
    applyStimulus(1'b0);
    checkOutput("post_rst.len_vld_end", len_vld, 1);
    checkOutput("post_rst.last_hi_len", last_hi_len, 1);

    // Overlapping matches on 1,0,1,1,0,1,1 (first element driven first)
    rstn = 1'b0;
    applyStimulus(1'b0);
    rstn = 1'b1;
    ovlSeq = 7'b1011011;
    ovlDet = 7'b0001001;
    ovlVld = 7'b0100100;
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(ovlSeq[i]);
      checkOutput($sformatf("ovl.det[%0d]", 6 - i), det, ovlDet[i]);
      checkOutput($sformatf("ovl.len_vld[%0d]", 6 - i), len_vld, ovlVld[i]);
    end
    checkOutput("ovl.match_cnt", match_cnt, 2);
    checkOutput("ovl.edge_cnt", edge_cnt, 2);
    applyStimulus(1'b0);
    checkOutput("ovl.det_after", det, 0);
    checkOutput("ovl.last_hi_len", last_hi_len, 2);

    // Run length: 0, five 1s, 0
    clr = 1'b1;
    applyStimulus(1'b0);
    clr = 1'b0;
    checkAllZero("clr1");
    applyStimulus(1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1);
      checkOutput($sformatf("run.len_vld_hi[%0d]", i), len_vld, 0);
    end
    applyStimulus(1'b0);
    checkOutput("run.len_vld", len_vld, 1);
    checkOutput("run.last_hi_len", last_hi_len, 5);
    checkOutput("run.edge_cnt", edge_cnt, 1);
    applyStimulus(1'b0);
    checkOutput("run.len_vld_single", len_vld, 0);
    checkOutput("run.last_hi_hold", last_hi_len, 5);

    // clr on the final pattern bit: match and edge discarded, history wiped
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("clrp.edge_pre", edge_cnt, 3);
    clr = 1'b1;
    applyStimulus(1'b1);
    clr = 1'b0;
    checkOutput("clrp.det", det, 0);
    checkOutput("clrp.match_cnt", match_cnt, 0);
    checkOutput("clrp.edge_cnt", edge_cnt, 0);
    clrSeq = 6'b011011;
    clrDet = 6'b000001;
    for (int i = 5; i >= 0; i--) begin
      applyStimulus(clrSeq[i]);
      checkOutput($sformatf("clrp.det[%0d]", 5 - i), det, clrDet[i]);
      if (i == 5) checkOutput("clrp.run_discard", len_vld, 0);
    end
    checkOutput("clrp.match_after", match_cnt, 1);

    // Run-length saturation: 70 ones
    clr = 1'b1;
    applyStimulus(1'b0);
    clr = 1'b0;
    applyStimulus(1'b0);
    repeat (70) applyStimulus(1'b1);
    checkOutput("sat.len_vld_hi", len_vld, 0);
    applyStimulus(1'b0);
    checkOutput("sat.len_vld", len_vld, 1);
    checkOutput("sat.last_hi_len", last_hi_len, 63);
    checkOutput("sat.edge_cnt", edge_cnt, 1);
`ifdef MON_SAT_EN
    checkOutput("sat.ovf", ovf, 1);
    repeat (3) applyStimulus(1'b0);
    checkOutput("sat.ovf_sticky", ovf, 1);
`endif
    clr = 1'b1;
    applyStimulus(1'b0);
    clr = 1'b0;
    checkAllZero("clr2");

    // Edge counter: 257 rising edges
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b0);
      applyStimulus(1'b1);
    end
    checkOutput("wrap.match_cnt", match_cnt, 0);
`ifdef MON_SAT_EN
    checkOutput("wrap.edge_cnt", edge_cnt, 255);
    checkOutput("wrap.ovf", ovf, 1);
`else
    checkOutput("wrap.edge_cnt", edge_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
